seconds_timer_sched: RTL

Multi-channel seconds-timeout scheduler that shares the one-per-second `tick` from `seconds_counter` among NCH requesters. Each requester arms a channel with a timeout in seconds. On every tick, one shared decrement unit scans the channels sequentially and pulses `expire` for each channel that reaches zero. It sits beside `seconds_counter` in the 100 MHz domain, and clients use it instead of instantiating private second counters.

---
 rtl/seconds_timer_pkg.sv | 6 +
 rtl/seconds_timer_sched.sv | 94 +++++++++
 2 files changed

// File: rtl/seconds_timer_pkg.sv
// seconds_timer_pkg: FSM encoding and default sizing shared by seconds_timer_sched and its instantiators.
package seconds_timer_pkg;
  typedef enum logic {IDLE, SCAN} state_e;
  localparam int NCH_DEF   = 4;
  localparam int SEC_W_DEF = 8;
endpackage

// File: rtl/seconds_timer_sched.sv
// seconds_timer_sched: NCH second-granularity timeouts served by one decrement unit scanning on each tick.
module seconds_timer_sched
  import seconds_timer_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int SEC_W = SEC_W_DEF,
  localparam int CH_W = $clog2(NCH)
) (
  input  logic             clk100,
  input  logic             reset,
  input  logic             tick,
  input  logic             arm_valid,
  output logic             arm_ready,
  input  logic [CH_W-1:0]  arm_chan,
  input  logic [SEC_W-1:0] arm_secs,
  input  logic [NCH-1:0]   cancel,
  output logic [NCH-1:0]   active,
  output logic [NCH-1:0]   expire,
  output logic             busy,
  output logic             overrun
);
  state_e           state_q, state_d;
  logic [CH_W-1:0]  idx_q, idx_d;
  logic             pend_q, pend_d;
  logic             ovr_q, ovr_d;
  logic [NCH-1:0]   act_q, act_d;
  logic [NCH-1:0]   exp_q, exp_d;
  logic [SEC_W-1:0] rem_q [NCH];
  logic [SEC_W-1:0] rem_d [NCH];
  assign arm_ready = state_q == IDLE;
  assign busy      = state_q == SCAN;
  assign active    = act_q;
  assign expire    = exp_q;
  assign overrun   = ovr_q;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    ovr_d   = ovr_q;
    rem_d   = rem_q;
    act_d   = act_q & ~cancel;
    exp_d   = '0;
    if (state_q == IDLE) begin
      if (arm_valid) begin
        rem_d[arm_chan] = arm_secs;
        act_d[arm_chan] = |arm_secs;
        exp_d[arm_chan] = ~|arm_secs;
      end
      if (tick || pend_q) begin
        state_d = SCAN;
        idx_d   = '0;
        pend_d  = 1'b0;
      end
    end else begin
      // act_d already reflects cancel, so a cancelled slot neither decrements nor expires
      if (act_d[idx_q]) begin
        if (rem_q[idx_q] == SEC_W'(1)) begin
          act_d[idx_q] = 1'b0;
          exp_d[idx_q] = 1'b1;
        end else begin
          rem_d[idx_q] = rem_q[idx_q] - 1'b1;
        end
      end
      if (tick && pend_q) ovr_d = 1'b1;
      if (idx_q == CH_W'(NCH - 1)) begin
        state_d = (tick || pend_q) ? SCAN : IDLE;
        idx_d   = '0;
        pend_d  = 1'b0;
      end else begin
        idx_d  = idx_q + 1'b1;
        pend_d = pend_q | tick;
      end
    end
  end
  always_ff @(posedge clk100) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
      act_q   <= '0;
      exp_q   <= '0;
      rem_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      act_q   <= act_d;
      exp_q   <= exp_d;
      rem_q   <= rem_d;
    end
  end
endmodule
